l1_instr_refill: RTL and testbench

Refill controller for the L1 instruction cache data array (64 lines × 128 bits). On a miss it fetches one 128-bit line from the next memory level as four 32-bit beats and assembles them. It then writes the line into the data array through its `we`/`we_next`/`addr`/`data` write port, and updates the tag array in the same cycle. It sits directly upstream of the data array and is driven by the fetch-side hit/miss logic; the `miss_next_i` path refills the line after the one addressed, for instructions that straddle a line boundary.

---
 rtl/l1_instr_refill.sv | 190 +++++++++++++++++++
 tb/tb_l1_instr_refill.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l1_instr_refill.sv
// l1_instr_refill: refill controller for the L1 instruction cache data array.
//
// On a miss it requests one line from the next memory level, collects four
// in-order beats into a line buffer, then writes the line into the data array
// and the tag into the tag array in the same cycle, and pulses done_o.
//
// Optional feature macro: L1_REFILL_BYPASS_EN enables the critical-word
// forward on bypass_valid_o/bypass_data_o. Without it those ports are tied to 0.
//
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   miss_i, miss_addr_i,
//   miss_next_i                  refill request (sampled only when idle)
//   busy_o, done_o               controller status, one-cycle completion pulse
//   mem_req_o, mem_addr_o,
//   mem_gnt_i                    line request handshake to next level
//   mem_rvalid_i, mem_rdata_i    returned beats, in order
//   dat_we_o, dat_we_next_o,
//   dat_addr_o, dat_data_o       data array write port
//   tag_we_o, tag_idx_o, tag_o   tag array write port
//   bypass_valid_o,
//   bypass_data_o                critical-word forward
module l1_instr_refill #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned IDX_WIDTH  = 6,
  parameter int unsigned LINE_WIDTH = 128,
  parameter int unsigned BEAT_WIDTH = 32,
  parameter int unsigned TAG_WIDTH  = ADDR_WIDTH - IDX_WIDTH - 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  miss_i,
  input  logic [ADDR_WIDTH-1:0] miss_addr_i,
  input  logic                  miss_next_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  mem_req_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  input  logic                  mem_gnt_i,
  input  logic                  mem_rvalid_i,
  input  logic [BEAT_WIDTH-1:0] mem_rdata_i,
  output logic                  dat_we_o,
  output logic                  dat_we_next_o,
  output logic [IDX_WIDTH-1:0]  dat_addr_o,
  output logic [LINE_WIDTH-1:0] dat_data_o,
  output logic                  tag_we_o,
  output logic [IDX_WIDTH-1:0]  tag_idx_o,
  output logic [TAG_WIDTH-1:0]  tag_o,
  output logic                  bypass_valid_o,
  output logic [BEAT_WIDTH-1:0] bypass_data_o
);

  localparam int unsigned LaWidth  = ADDR_WIDTH - 4;
  localparam int unsigned NumBeats = LINE_WIDTH / BEAT_WIDTH;
  localparam int unsigned CntWidth = $clog2(NumBeats);

  typedef enum logic [2:0] {StIdle, StReq, StCollect, StWrite, StDone} state_e;

  state_e                state_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  mem_req_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic                  dat_we_q;
  logic                  dat_we_next_q;
  logic                  tag_we_q;
  logic [LaWidth-1:0]    la_q;
  logic [IDX_WIDTH-1:0]  idx_q;
  logic                  next_q;
  logic [CntWidth-1:0]   cnt_q;
  logic [LINE_WIDTH-1:0] line_q;

  // Line address to fetch; the +1 wraps within the line-address space.
  logic [LaWidth-1:0] la_d;
  assign la_d = miss_addr_i[ADDR_WIDTH-1:4] + LaWidth'(miss_next_i);

  // Byte offset bits never matter; the word bits only feed the bypass path.
  logic unused_addr_bits;
  assign unused_addr_bits = ^miss_addr_i[3:0];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= StIdle;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      mem_req_q     <= 1'b0;
      mem_addr_q    <= '0;
      dat_we_q      <= 1'b0;
      dat_we_next_q <= 1'b0;
      tag_we_q      <= 1'b0;
      la_q          <= '0;
      idx_q         <= '0;
      next_q        <= 1'b0;
      cnt_q         <= '0;
      line_q        <= '0;
    end else begin
      dat_we_q      <= 1'b0;
      dat_we_next_q <= 1'b0;
      tag_we_q      <= 1'b0;
      done_q        <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (miss_i) begin
            la_q       <= la_d;
            idx_q      <= miss_addr_i[IDX_WIDTH+3:4];
            next_q     <= miss_next_i;
            mem_req_q  <= 1'b1;
            mem_addr_q <= {la_d, 4'b0000};
            busy_q     <= 1'b1;
            state_q    <= StReq;
          end
        end
        StReq: begin
          if (mem_gnt_i) begin
            mem_req_q <= 1'b0;
            cnt_q     <= '0;
            state_q   <= StCollect;
          end
        end
        StCollect: begin
          if (mem_rvalid_i) begin
            line_q[cnt_q*BEAT_WIDTH +: BEAT_WIDTH] <= mem_rdata_i;
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == CntWidth'(NumBeats - 1)) begin
              dat_we_q      <= 1'b1;
              dat_we_next_q <= next_q;
              tag_we_q      <= 1'b1;
              state_q       <= StWrite;
            end
          end
        end
        StWrite: begin
          done_q  <= 1'b1;
          state_q <= StDone;
        end
        StDone: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign mem_req_o     = mem_req_q;
  assign mem_addr_o    = mem_addr_q;
  assign dat_we_o      = dat_we_q;
  assign dat_we_next_o = dat_we_next_q;
  assign dat_addr_o    = idx_q;
  assign dat_data_o    = line_q;
  assign tag_we_o      = tag_we_q;
  assign tag_idx_o     = la_q[IDX_WIDTH-1:0];
  assign tag_o         = la_q[LaWidth-1:IDX_WIDTH];

`ifdef L1_REFILL_BYPASS_EN
  logic [CntWidth-1:0]   word_q;
  logic                  byp_valid_q;
  logic [BEAT_WIDTH-1:0] byp_data_q;
  logic                  byp_hit;

  // Forward the requested word only for a same-line refill; a next-line
  // refill does not contain the word the fetch is waiting for.
  assign byp_hit = (state_q == StCollect) && mem_rvalid_i && !next_q && (cnt_q == word_q);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      word_q      <= '0;
      byp_valid_q <= 1'b0;
      byp_data_q  <= '0;
    end else begin
      if (state_q == StIdle && miss_i) begin
        word_q <= miss_addr_i[2 +: CntWidth];
      end
      byp_valid_q <= byp_hit;
      if (byp_hit) begin
        byp_data_q <= mem_rdata_i;
      end
    end
  end

  assign bypass_valid_o = byp_valid_q;
  assign bypass_data_o  = byp_data_q;
`else
  assign bypass_valid_o = 1'b0;
  assign bypass_data_o  = '0;
`endif

endmodule

// File: tb/tb_l1_instr_refill.sv
// Testbench for l1_instr_refill: directed cases plus randomized refills with
// stalls, stray beats and ignored misses; a monitor checks writes against a
// scoreboard filled by the stimulus process.
module tb_l1_instr_refill;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b1;
  logic         miss_i = 1'b0;
  logic [31:0]  miss_addr_i = '0;
  logic         miss_next_i = 1'b0;
  logic         busy_o, done_o, mem_req_o;
  logic [31:0]  mem_addr_o;
  logic         mem_gnt_i = 1'b0;
  logic         mem_rvalid_i = 1'b0;
  logic [31:0]  mem_rdata_i = '0;
  logic         dat_we_o, dat_we_next_o;
  logic [5:0]   dat_addr_o;
  logic [127:0] dat_data_o;
  logic         tag_we_o;
  logic [5:0]   tag_idx_o;
  logic [21:0]  tag_o;
  logic         bypass_valid_o;
  logic [31:0]  bypass_data_o;

  always #5 clk_i = ~clk_i;

  l1_instr_refill dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .miss_i         (miss_i),
    .miss_addr_i    (miss_addr_i),
    .miss_next_i    (miss_next_i),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .mem_req_o      (mem_req_o),
    .mem_addr_o     (mem_addr_o),
    .mem_gnt_i      (mem_gnt_i),
    .mem_rvalid_i   (mem_rvalid_i),
    .mem_rdata_i    (mem_rdata_i),
    .dat_we_o       (dat_we_o),
    .dat_we_next_o  (dat_we_next_o),
    .dat_addr_o     (dat_addr_o),
    .dat_data_o     (dat_data_o),
    .tag_we_o       (tag_we_o),
    .tag_idx_o      (tag_idx_o),
    .tag_o          (tag_o),
    .bypass_valid_o (bypass_valid_o),
    .bypass_data_o  (bypass_data_o)
  );

  typedef struct {
    logic [5:0]   dat_addr;
    logic         we_next;
    logic [127:0] data;
    logic [5:0]   tag_idx;
    logic [21:0]  tag;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] mem_q[$];
  logic [31:0] byp_q[$];

  // Owned by the stimulus process.
  int   exp_wr = 0;
  int   tmo_cnt = 0;
  logic expect_zero = 1'b0;
  logic end_chk = 1'b0;

  // Owned by the monitor process.
  int          total = 0;
  int          bad = 0;
  int          wr_cnt = 0;
  int          tmo_seen = 0;
  logic        end_done = 1'b0;
  logic        prev_we = 1'b0;
  logic        prev_done = 1'b0;
  logic        prev_req = 1'b0;
  logic        prev_rvalid = 1'b0;
  logic [31:0] prev_rdata = '0;
  logic [31:0] cur_req_addr = '0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  always @(negedge clk_i) begin
    exp_t e;
    if (rst_i) begin
      prev_we   = 1'b0;
      prev_done = 1'b0;
      prev_req  = 1'b0;
    end else begin
      if (expect_zero) begin
        check("all_outputs_zero",
              256'({mem_req_o, mem_addr_o, busy_o, done_o, dat_we_o, dat_we_next_o, dat_addr_o,
                    dat_data_o, tag_we_o, tag_idx_o, tag_o, bypass_valid_o, bypass_data_o}),
              256'(0));
      end
      if (mem_req_o && !prev_req) begin
        if (mem_q.size() == 0) check("unexpected_req", 256'(1), 256'(0));
        else cur_req_addr = mem_q.pop_front();
      end
      if (mem_req_o) check("mem_addr", 256'(mem_addr_o), 256'(cur_req_addr));
      if (dat_we_o) begin
        wr_cnt++;
        if (exp_q.size() == 0) begin
          check("unexpected_write", 256'(1), 256'(0));
        end else begin
          e = exp_q.pop_front();
          check("dat_addr", 256'(dat_addr_o), 256'(e.dat_addr));
          check("dat_we_next", 256'(dat_we_next_o), 256'(e.we_next));
          check("dat_data", 256'(dat_data_o), 256'(e.data));
          check("tag_we", 256'(tag_we_o), 256'(1));
          check("tag_idx", 256'(tag_idx_o), 256'(e.tag_idx));
          check("tag", 256'(tag_o), 256'(e.tag));
        end
      end
      if (done_o || prev_we) check("done_after_write", 256'(done_o), 256'(prev_we));
      if (done_o) check("busy_in_done", 256'(busy_o), 256'(1));
      if (prev_done) check("idle_after_done", 256'(busy_o), 256'(0));
`ifdef L1_REFILL_BYPASS_EN
      if (bypass_valid_o) begin
        if (byp_q.size() == 0) check("unexpected_bypass", 256'(1), 256'(0));
        else check("bypass_data", 256'(bypass_data_o), 256'(byp_q.pop_front()));
        check("bypass_timing", 256'({prev_rvalid, prev_rdata}), 256'({1'b1, bypass_data_o}));
      end
`else
      check("bypass_off", 256'({bypass_valid_o, bypass_data_o}), 256'(0));
`endif
      if (tmo_cnt != tmo_seen) begin
        tmo_seen++;
        check("done_timeout", 256'(0), 256'(1));
      end
      if (end_chk && !end_done) begin
        end_done = 1'b1;
        check("exp_left", 256'(exp_q.size()), 256'(0));
        check("req_left", 256'(mem_q.size()), 256'(0));
        check("bypass_left", 256'(byp_q.size()), 256'(0));
        check("write_count", 256'(wr_cnt), 256'(exp_wr));
      end
      prev_we   = dat_we_o;
      prev_done = done_o;
      prev_req  = mem_req_o;
    end
    prev_rvalid = mem_rvalid_i;
    prev_rdata  = mem_rdata_i;
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Push the expected refill outcome, computed from the address rules.
  task automatic expect_refill(input logic [31:0] addr, input logic nxt, input logic [127:0] line);
    exp_t        e;
    logic [31:0] la;
    la         = ((addr >> 4) + 32'(nxt)) & 32'h0FFF_FFFF;
    e.dat_addr = 6'((addr >> 4) % 64);
    e.we_next  = nxt;
    e.data     = line;
    e.tag_idx  = 6'(la % 64);
    e.tag      = 22'(la / 64);
    exp_q.push_back(e);
    exp_wr++;
`ifdef L1_REFILL_BYPASS_EN
    if (!nxt) byp_q.push_back(line[32*((addr >> 2) % 4) +: 32]);
`endif
  endtask

  task automatic refill(input logic [31:0] addr, input logic nxt, input int gdelay,
                        input int gapmax, input bit stray, input logic [127:0] line);
    bit got;
    expect_refill(addr, nxt, line);
    mem_q.push_back((((addr >> 4) + 32'(nxt)) & 32'h0FFF_FFFF) << 4);
    miss_i = 1'b1;
    miss_addr_i = addr;
    miss_next_i = nxt;
    tick();
    miss_i = 1'b0;
    miss_addr_i = $urandom();
    miss_next_i = 1'($urandom_range(0, 1));
    for (int d = 0; d < gdelay; d++) begin
      mem_rvalid_i = stray ? 1'($urandom_range(0, 1)) : 1'b0;
      mem_rdata_i = $urandom();
      miss_i = stray ? 1'($urandom_range(0, 1)) : 1'b0;
      tick();
    end
    mem_gnt_i = 1'b1;
    mem_rvalid_i = 1'b0;
    tick();
    mem_gnt_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      int gaps = (gapmax > 0) ? int'($urandom_range(0, gapmax)) : 0;
      for (int g = 0; g < gaps; g++) begin
        mem_rvalid_i = 1'b0;
        miss_i = stray ? 1'($urandom_range(0, 1)) : 1'b0;
        tick();
      end
      miss_i = 1'b0;
      mem_rvalid_i = 1'b1;
      mem_rdata_i = line[32*k +: 32];
      tick();
    end
    mem_rvalid_i = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk_i);
      if (done_o) got = 1'b1;
    end
    if (!got) tmo_cnt++;
    tick();
  endtask

  initial begin
    repeat (3) tick();
    rst_i = 1'b0;
    // Stray beats while idle must leave every output at its reset value.
    expect_zero = 1'b1;
    for (int i = 0; i < 3; i++) begin
      mem_rvalid_i = 1'b1;
      mem_rdata_i = $urandom();
      tick();
    end
    mem_rvalid_i = 1'b0;
    expect_zero = 1'b0;

    refill(32'h0000_1234, 1'b0, 0, 0, 1'b0, 128'h44444444_33333333_22222222_11111111);
    refill(32'h0000_03F8, 1'b1, 0, 0, 1'b0, 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA);
    refill(32'h0000_5678, 1'b0, 0, 0, 1'b0, 128'h0BAD_F00D_1234_5678_9ABC_DEF0_CAFE_BABE);
    refill(32'hFFFF_FFF4, 1'b1, 3, 3, 1'b1, {$urandom(), $urandom(), $urandom(), $urandom()});
    refill($urandom(), 1'b0, 3, 3, 1'b1, {$urandom(), $urandom(), $urandom(), $urandom()});

    // Abort a refill after its third beat.
    mem_q.push_back(32'h0000_ABD0);
    miss_i = 1'b1;
    miss_addr_i = 32'h0000_ABCC;
    miss_next_i = 1'b1;
    tick();
    miss_i = 1'b0;
    mem_gnt_i = 1'b1;
    tick();
    mem_gnt_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      mem_rvalid_i = 1'b1;
      mem_rdata_i = $urandom();
      tick();
    end
    mem_rvalid_i = 1'b0;
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    expect_zero = 1'b1;
    for (int i = 0; i < 2; i++) begin
      mem_rvalid_i = 1'b1;
      mem_rdata_i = $urandom();
      tick();
    end
    mem_rvalid_i = 1'b0;
    expect_zero = 1'b0;
    refill(32'h0000_ABCC, 1'b0, 1, 1, 1'b0, 128'h01020304_05060708_090A0B0C_0D0E0F10);

    for (int n = 0; n < 40; n++) begin
      int idle = int'($urandom_range(0, 2));
      for (int i = 0; i < idle; i++) begin
        mem_rvalid_i = 1'($urandom_range(0, 1));
        mem_rdata_i = $urandom();
        tick();
      end
      mem_rvalid_i = 1'b0;
      refill($urandom(), 1'($urandom_range(0, 1)), int'($urandom_range(0, 4)), 2, 1'b1,
             {$urandom(), $urandom(), $urandom(), $urandom()});
    end

    end_chk = 1'b1;
    tick();
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
